ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain loader sitting directly upstream of the routing/CLB configuration flip-flop chain. It drives the chain's ccff_head input.
- Accepts bitstream words over a valid/ready stream and serializes them one bit per prog_clk onto ccff_head.
- Emits a shift enable that gates the chain clock, and stops after exactly CHAIN_LEN bits.
- Optionally computes a CRC over the bits emerging at ccff_tail, which is the previous configuration, for readback integrity.

Parameters:
- DATA_W, 8: width of incoming bitstream words.
- CHAIN_LEN, 10: total configuration bits in the attached chain; set to the fabric total at integration.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter (derived; do not override).

Ports:
- prog_clk, in, 1: programming clock.
- pReset, in, 1: asynchronous, active-low reset.
- start, in, 1: begin a load; sampled in IDLE or DONE only.
- abort, in, 1: synchronous abort back to IDLE.
- s_data, in, DATA_W: bitstream word; LSB is shifted first.
- s_valid, in, 1: s_data valid.
- s_ready, out, 1: loader accepts the word this cycle.
- ccff_head, out, 1: serial bit into the chain.
- ccff_tail, in, 1: serial bit out of the chain end.
- ccff_en, out, 1: chain advances on a prog_clk edge only while this is 1.
- busy, out, 1: load in progress.
- done, out, 1: CHAIN_LEN bits shifted; level signal.
- bit_count, out, CNT_W: bits shifted so far in the current load.
- readback_crc, out, 16: CRC over ccff_tail bits (see Optional Feature).

Behaviour:
- Reset (pReset=0, asynchronous): state=IDLE. All outputs are 0: s_ready, ccff_head, ccff_en, busy, done, bit_count, readback_crc.
- Reset mid-load: the chain contents are undefined; the loader restarts in IDLE and the host must reload from the beginning.

State machine:
- IDLE --start--> LOAD. Clears bit_count, done and the CRC; busy=1.
- LOAD: s_ready=1 and ccff_en=0 (chain holds). On s_valid&&s_ready the word is captured into the shift register, bit_idx=0, and the state goes to SHIFT.
- SHIFT: ccff_head=shreg[bit_idx] and ccff_en=1 every cycle. bit_count increments and bit_idx increments.
  - When bit_count reaches CHAIN_LEN (that cycle's bit being the last): go to DONE. Remaining word bits are discarded.
  - Else, when bit_idx==DATA_W-1: s_ready=1 in that same cycle.
    - If s_valid: capture the next word, giving back-to-back shifting with no bubble.
    - Else: go to LOAD.
- DONE: done=1, busy=0, ccff_en=0, s_ready=0. start --> LOAD (new load).
- abort (any state except IDLE): the next cycle is IDLE. ccff_en=0, done=0, busy=0 from that cycle on; a word offered in the abort cycle is not accepted (s_ready=0).
- Precedence: pReset > abort > start. start is ignored while busy.

Timing and handshake:
- First ccff_en cycle is the cycle after the first word is accepted. Latency start->first bit is 2 cycles when s_valid is already high.
- Throughput is one bit per cycle while the stream keeps up.
- Stream rule: s_data must hold while s_valid=1 and s_ready=0. Words offered in IDLE or DONE are not consumed.
- ccff_head is registered and changes only on cycles where ccff_en=1; it holds its last value otherwise.
- CHAIN_LEN not a multiple of DATA_W: the last word is partially used; its upper bits are dropped silently.

Optional Feature:
- Macro: CCFF_READBACK_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first serial update, no reflection, no final XOR) is updated with ccff_tail on every ccff_en cycle.
  - The CRC is cleared to 0xFFFF on start and is readable on readback_crc. It is valid in DONE, covers exactly CHAIN_LEN bits, and holds until the next start.
  - Sampling point: ccff_tail is sampled in the same cycle as the enabled edge, i.e. the pre-shift tail value.
- Not defined: readback_crc is tied to 0 and no CRC logic is instantiated.

Decomposition:
- Package ccff_chain_loader_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - a function for the one-bit CRC update.
- One sub-module, ccff_serial_crc16 (inputs: clk, reset, clear, en, bit_in; output: crc). It is instantiated only under CCFF_READBACK_CRC_EN.

Test Plan:
- CHAIN_LEN=10, DATA_W=8, words 0xA5 then 0x03, s_valid always high -> exactly 10 consecutive ccff_en cycles. ccff_head sequence is 1,0,1,0,0,1,0,1,1,1. done=1 after the 10th bit; the upper 6 bits of 0x03 are discarded.
- Same load with s_valid dropped for 3 cycles after the first word -> ccff_en stays 0 for those 3 cycles, the chain holds, and bit_count stalls at 8.
- Model a 10-bit chain in the bench, load 0x3FF pattern then 0x000 pattern -> chain reads all-1 after load 1 and all-0 after load 2.
- Assert abort at bit 5 -> IDLE next cycle, ccff_en=0, done=0. A new start/load of 10 bits completes normally.
- Assert pReset low asynchronously mid-SHIFT -> all outputs 0 immediately, even without a clock edge.
- With CCFF_READBACK_CRC_EN: chain preloaded with 10'b1111100000, then load any data -> readback_crc equals the CRC-16-CCITT of those 10 tail bits. Without the macro -> readback_crc==0.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and CRC-16-CCITT helpers for the configuration-chain loader.
package ccff_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-first serial update, no reflection, no final XOR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic feedback;
        feedback = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_serial_crc16.sv
// Bit-serial CRC-16-CCITT accumulator over the bits leaving the configuration chain.
module ccff_serial_crc16
    import ccff_chain_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc <= '0;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes a valid/ready word stream onto a CHAIN_LEN-bit configuration chain.
// Readback CRC over ccff_tail is built only when CCFF_READBACK_CRC_EN is defined.
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 10,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [15:0]       readback_crc
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              last_bit;
    logic              word_end;
    logic              accept;
    logic              load_start;

    // The chain's final bit wins over a word boundary, so a partial last word is dropped.
    assign last_bit   = (state == SHIFT) && (bit_count == LAST_CNT);
    assign word_end   = (state == SHIFT) && (bit_idx == LAST_IDX) && !last_bit;
    assign s_ready    = !abort && ((state == LOAD) || word_end);
    assign accept     = s_ready && s_valid;
    assign load_start = !abort && start && ((state == IDLE) || (state == DONE));

    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            ccff_head <= 1'b0;
            ccff_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
        end else if (abort) begin
            state   <= IDLE;
            ccff_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        bit_count <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        shreg     <= s_data;
                        ccff_head <= s_data[0];
                        bit_idx   <= '0;
                        ccff_en   <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_count <= bit_count + CNT_W'(1);
                    if (last_bit) begin
                        state   <= DONE;
                        ccff_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (word_end) begin
                        if (accept) begin
                            shreg     <= s_data;
                            ccff_head <= s_data[0];
                            bit_idx   <= '0;
                        end else begin
                            state   <= LOAD;
                            ccff_en <= 1'b0;
                        end
                    end else begin
                        bit_idx   <= bit_idx + IDX_W'(1);
                        ccff_head <= shreg[bit_idx + IDX_W'(1)];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CCFF_READBACK_CRC_EN
    // The tail is sampled on the same edge the chain advances, i.e. the pre-shift value.
    ccff_serial_crc16 u_crc (
        .clk    (prog_clk),
        .reset  (pReset),
        .clear  (load_start),
        .en     (ccff_en),
        .bit_in (ccff_tail),
        .crc    (readback_crc)
    );
`else
    logic unused_tail;
    assign unused_tail  = ccff_tail;
    assign readback_crc = '0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed scoreboard bench for ccff_chain_loader with a behavioural 10-bit chain model.
module tb_ccff_chain_loader;

    localparam int DATA_W    = 8;
    localparam int CHAIN_LEN = 10;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    logic              prog_clk = 1'b0;
    logic              pReset   = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [DATA_W-1:0] s_data   = '0;
    logic              s_valid  = 1'b0;
    logic              s_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;
    logic [15:0]       readback_crc;

    logic [CHAIN_LEN-1:0] chain_q = '0;

    ccff_chain_loader #(
        .DATA_W    (DATA_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_en      (ccff_en),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count),
        .readback_crc (readback_crc)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters chain_q[0], tail leaves from the top bit.
    assign ccff_tail = chain_q[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        if (ccff_en === 1'b1) chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head};
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic              exp_q[$];
    logic [DATA_W-1:0] word_q[$];
    int pushed, en_seen, en_run, en_run_max, gap_left, words_acc;
    int cycle_no = 0, start_cycle, first_en_cycle;
    logic [CHAIN_LEN-1:0] head_seq;
    logic last_ready;
    logic [15:0] exp_crc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [CHAIN_LEN-1:0] pattern);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = CHAIN_LEN - 1; i >= 0; i--) begin
            fb = c[15] ^ pattern[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // One cycle: drive inputs after the falling edge, settle, compare, then account the handshake.
    task automatic tick(input logic st, input logic ab);
        logic              exp_bit;
        logic              gap_now;
        logic [DATA_W-1:0] w;
        @(negedge prog_clk);
        cycle_no++;
        start   = st;
        abort   = ab;
        gap_now = (gap_left > 0) && (words_acc == 1) && (en_seen >= DATA_W - 1);
        if (gap_now) gap_left--;
        s_valid = (word_q.size() > 0) && !gap_now;
        s_data  = (word_q.size() > 0) ? word_q[0] : '0;
        #1;
        if (ab) check("ready_in_abort", s_ready, 0);
        if (gap_now && en_seen == DATA_W) begin
            check("stall_en", ccff_en, 0);
            check("stall_count", bit_count, DATA_W);
        end
        if (ccff_en === 1'b1) begin
            if (en_seen == 0) first_en_cycle = cycle_no;
            check("bit_count", bit_count, en_seen);
            check("sb_depth", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check("ccff_head", ccff_head, exp_bit);
            end
            if (en_seen < CHAIN_LEN) head_seq[en_seen] = ccff_head;
            en_seen++;
            en_run++;
            if (en_run > en_run_max) en_run_max = en_run;
        end else begin
            en_run = 0;
        end
        last_ready = s_ready;
        if (s_valid && (s_ready === 1'b1)) begin
            w = word_q.pop_front();
            words_acc++;
            for (int i = 0; i < DATA_W; i++) begin
                if (pushed < CHAIN_LEN) begin
                    exp_q.push_back(w[i]);
                    pushed++;
                end
            end
        end
    endtask

    task automatic begin_load(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1, input int gap);
        word_q.delete();
        word_q.push_back(w0);
        word_q.push_back(w1);
        exp_q.delete();
        pushed     = 0;
        en_seen    = 0;
        en_run     = 0;
        en_run_max = 0;
        gap_left   = gap;
        words_acc  = 0;
        head_seq   = '0;
        tick(1'b1, 1'b0);
        start_cycle = cycle_no;
    endtask

    task automatic run_load(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1, input int gap);
        int budget;
        begin_load(w0, w1, gap);
        budget = 0;
        do begin
            tick(1'b0, 1'b0);
            budget++;
        end while (done !== 1'b1 && budget < 40);
        check("load_done", done, 1);
        check("busy_in_done", busy, 0);
        check("en_in_done", ccff_en, 0);
        check("final_count", bit_count, CHAIN_LEN);
        check("bits_shifted", en_seen, CHAIN_LEN);
        check("sb_empty", exp_q.size(), 0);
        check("first_bit_latency", first_en_cycle - start_cycle, 2);
        word_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_ccff_head"}, ccff_head, 0);
        check({tag, "_ccff_en"}, ccff_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bit_count"}, bit_count, 0);
        check({tag, "_crc"}, readback_crc, 0);
    endtask

    initial begin
        int budget;
        gap_left  = 0;
        words_acc = 0;
        en_seen   = 0;
        pushed    = 0;

        // Reset state
        repeat (2) @(negedge prog_clk);
        #1;
        check_all_zero("reset");
        @(negedge prog_clk);
        pReset = 1'b1;

        // Back-to-back load, partial last word
        run_load(8'hA5, 8'h03, 0);
        check("head_sequence", head_seq, 10'b1110100101);
        check("consecutive_en", en_run_max, CHAIN_LEN);

        // Word offered in DONE is not consumed
        word_q.push_back(8'h55);
        tick(1'b0, 1'b0);
        check("ready_in_done", last_ready, 0);
        check("word_kept_in_done", word_q.size(), 1);
        word_q.delete();

        // Stream stalls for 3 cycles where the second word is due
        run_load(8'hA5, 8'h03, 3);
        check("stall_head_sequence", head_seq, 10'b1110100101);
        check("stall_run", en_run_max, DATA_W);

        // Chain contents after all-ones then all-zeros loads
        run_load(8'hFF, 8'hFF, 0);
        check("chain_all_ones", chain_q, 10'h3FF);
        run_load(8'h00, 8'h00, 0);
        check("chain_all_zeros", chain_q, 10'h000);

        // Abort while waiting for a word: offered word must not be taken
        begin_load(8'hA5, 8'h03, 0);
        tick(1'b0, 1'b1);
        check("abort_load_word_kept", word_q.size(), 2);
        tick(1'b0, 1'b0);
        check("abort_load_busy", busy, 0);
        check("abort_load_en", ccff_en, 0);

        // Abort at bit 5, then a clean reload
        begin_load(8'hA5, 8'h03, 0);
        budget = 0;
        while (en_seen < 5 && budget < 20) begin
            tick(1'b0, 1'b0);
            budget++;
        end
        check("abort_reached_bit5", en_seen, 5);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("abort_en", ccff_en, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", last_ready, 0);
        run_load(8'hA5, 8'h03, 0);
        check("reload_head_sequence", head_seq, 10'b1110100101);

        // Readback CRC over the previous chain image
        run_load(8'h1F, 8'h00, 0);
        check("chain_preload", chain_q, 10'b1111100000);
        run_load(8'hA5, 8'h03, 0);
`ifdef CCFF_READBACK_CRC_EN
        exp_crc = ref_crc(10'b1111100000);
`else
        exp_crc = 16'h0000;
`endif
        check("readback_crc", readback_crc, exp_crc);
        tick(1'b0, 1'b0);
        check("readback_crc_hold", readback_crc, exp_crc);

        // Asynchronous reset in the middle of SHIFT
        begin_load(8'hFF, 8'hFF, 0);
        repeat (4) tick(1'b0, 1'b0);
        check("pre_reset_en", ccff_en, 1);
        check("pre_reset_head", ccff_head, 1);
        @(negedge prog_clk);
        #2;
        pReset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge prog_clk);
        word_q.delete();
        start   = 1'b0;
        s_valid = 1'b0;
        pReset  = 1'b1;
        tick(1'b0, 1'b0);
        check("post_reset_idle_busy", busy, 0);
        check("post_reset_idle_ready", s_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

endmodule
